obj_ram_arbiter: RTL and testbench

- Shares the single write port of the object RAM between three sequencing writers: player bullets (req 0), enemy bullets (req 1) and enemy spawner (req 2).
- Each writer requests the port and performs a multi-cycle record burst (status, direction, x, y) while granted, then pulses done.
- Arbitration is round-robin with a per-grant watchdog, so a hung writer cannot starve the others.
- Sits between the three writers and the RAM write port.

---
 rtl/obj_ram_arbiter_if.sv | 32 +++
 rtl/obj_ram_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_obj_ram_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/obj_ram_arbiter_if.sv
// Bus between the three object-RAM writers and the arbiter, plus the RAM write port.
// master = writer/RAM side, slave = arbiter side.
interface obj_ram_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [2:0]          req;
    logic [2:0]          done;
    logic [3*ADDR_W-1:0] addr_in;
    logic [3*DATA_W-1:0] data_in;
    logic [2:0]          we_in;
    logic [2:0]          grant;
    logic [ADDR_W-1:0]   mem_address;
    logic [DATA_W-1:0]   mem_data;
    logic                mem_we;
    logic                busy;
    logic                timeout_err;
    logic [1:0]          timeout_id;
    logic                range_err;

    modport master (
        output req, done, addr_in, data_in, we_in,
        input  grant, mem_address, mem_data, mem_we, busy,
        input  timeout_err, timeout_id, range_err
    );

    modport slave (
        input  req, done, addr_in, data_in, we_in,
        output grant, mem_address, mem_data, mem_we, busy,
        output timeout_err, timeout_id, range_err
    );
endinterface

// File: rtl/obj_ram_arbiter.sv
// Round-robin arbiter with per-grant watchdog for the object RAM write port.
// Optional per-owner address window check enabled by OBJ_RAM_RANGE_CHECK_EN.
//
// state | meaning
// IDLE  | no owner; pick next requester round-robin from r_rr_ptr
// OWN   | owner's addr/data/we forwarded to the RAM; hold counter running
// GAP   | one-cycle bubble with grant and mem_we low before the next pick
module obj_ram_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64,
    parameter int R0_LO   = 192,
    parameter int R0_HI   = 255,
    parameter int R1_LO   = 64,
    parameter int R1_HI   = 191,
    parameter int R2_LO   = 0,
    parameter int R2_HI   = 63
) (
    input logic               clk,
    input logic               reset,
    obj_ram_arbiter_if.slave  bus
);

    localparam int                CNT_W    = 8;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    // Window test is (addr - LO) <= (HI - LO) in modular arithmetic
    localparam logic [ADDR_W-1:0] LO0   = ADDR_W'(R0_LO);
    localparam logic [ADDR_W-1:0] SPAN0 = ADDR_W'(R0_HI - R0_LO);
    localparam logic [ADDR_W-1:0] LO1   = ADDR_W'(R1_LO);
    localparam logic [ADDR_W-1:0] SPAN1 = ADDR_W'(R1_HI - R1_LO);
    localparam logic [ADDR_W-1:0] LO2   = ADDR_W'(R2_LO);
    localparam logic [ADDR_W-1:0] SPAN2 = ADDR_W'(R2_HI - R2_LO);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            r_state;
    logic [2:0]        r_grant;
    logic [1:0]        r_owner;
    logic [1:0]        r_rr_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic              r_timeout_err;
    logic [1:0]        r_timeout_id;

    logic [ADDR_W-1:0] w_own_addr;
    logic [DATA_W-1:0] w_own_data;
    logic              w_own_we;
    logic              w_own_req;
    logic              w_own_done;
    logic [1:0]        w_next1;
    logic [1:0]        w_next2;
    logic [1:0]        w_pick;
    logic [ADDR_W-1:0] w_mem_address;
    logic [DATA_W-1:0] w_mem_data;
    logic              w_mem_we;
    logic              w_range_err;

    always_comb begin
        w_own_addr = '0;
        w_own_data = '0;
        w_own_we   = 1'b0;
        w_own_req  = 1'b0;
        w_own_done = 1'b0;
        case (r_owner)
            2'd0: begin
                w_own_addr = bus.addr_in[0 +: ADDR_W];
                w_own_data = bus.data_in[0 +: DATA_W];
                w_own_we   = bus.we_in[0];
                w_own_req  = bus.req[0];
                w_own_done = bus.done[0];
            end
            2'd1: begin
                w_own_addr = bus.addr_in[ADDR_W +: ADDR_W];
                w_own_data = bus.data_in[DATA_W +: DATA_W];
                w_own_we   = bus.we_in[1];
                w_own_req  = bus.req[1];
                w_own_done = bus.done[1];
            end
            2'd2: begin
                w_own_addr = bus.addr_in[2*ADDR_W +: ADDR_W];
                w_own_data = bus.data_in[2*DATA_W +: DATA_W];
                w_own_we   = bus.we_in[2];
                w_own_req  = bus.req[2];
                w_own_done = bus.done[2];
            end
            default: ;
        endcase
    end

    // Search order rr_ptr+1, rr_ptr+2, rr_ptr (mod 3)
    always_comb begin
        w_next1 = (r_rr_ptr == 2'd2) ? 2'd0 : r_rr_ptr + 2'd1;
        w_next2 = (w_next1 == 2'd2) ? 2'd0 : w_next1 + 2'd1;
        if (bus.req[w_next1]) begin
            w_pick = w_next1;
        end else if (bus.req[w_next2]) begin
            w_pick = w_next2;
        end else begin
            w_pick = r_rr_ptr;
        end
    end

`ifdef OBJ_RAM_RANGE_CHECK_EN
    logic w_in_range;

    always_comb begin
        w_in_range = 1'b0;
        case (r_owner)
            2'd0:    w_in_range = ((w_own_addr - LO0) <= SPAN0);
            2'd1:    w_in_range = ((w_own_addr - LO1) <= SPAN1);
            2'd2:    w_in_range = ((w_own_addr - LO2) <= SPAN2);
            default: w_in_range = 1'b0;
        endcase
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{LO0, SPAN0, LO1, SPAN1, LO2, SPAN2};
`endif

    always_comb begin
        w_mem_address = '0;
        w_mem_data    = '0;
        w_mem_we      = 1'b0;
        w_range_err   = 1'b0;
        if (r_state == OWN) begin
            w_mem_address = w_own_addr;
            w_mem_data    = w_own_data;
`ifdef OBJ_RAM_RANGE_CHECK_EN
            w_mem_we      = w_own_we & w_in_range;
            w_range_err   = w_own_we & ~w_in_range;
`else
            w_mem_we      = w_own_we;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_grant       <= 3'b000;
            r_owner       <= 2'd0;
            r_rr_ptr      <= 2'd2;
            r_cnt         <= '0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_timeout_id  <= 2'd0;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|bus.req) begin
                        r_owner  <= w_pick;
                        r_rr_ptr <= w_pick;
                        r_grant  <= 3'b001 << w_pick;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= OWN;
                    end
                end
                OWN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_own_done || !w_own_req || (r_cnt == CNT_LAST)) begin
                        r_grant <= 3'b000;
                        r_state <= GAP;
                        // Only a watchdog expiry counts as an error; done/release win ties
                        if (!w_own_done && w_own_req) begin
                            r_timeout_err <= 1'b1;
                            r_timeout_id  <= r_owner;
                        end
                    end
                end
                GAP: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_grant <= 3'b000;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant       = r_grant;
    assign bus.busy        = r_busy;
    assign bus.timeout_err = r_timeout_err;
    assign bus.timeout_id  = r_timeout_id;
    assign bus.mem_address = w_mem_address;
    assign bus.mem_data    = w_mem_data;
    assign bus.mem_we      = w_mem_we;
    assign bus.range_err   = w_range_err;

endmodule

// File: tb/tb_obj_ram_arbiter.sv
// Directed bench for obj_ram_arbiter: vector table plus rotation, watchdog and reset sequences.
// Expected range-check results follow OBJ_RAM_RANGE_CHECK_EN as compiled.
module tb_obj_ram_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;

`ifdef OBJ_RAM_RANGE_CHECK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    obj_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    obj_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0] req;
        logic [2:0] done;
        logic [2:0] we;
        logic [7:0] a0;
        logic [7:0] d0;
        logic [2:0] e_grant;
        logic       e_we;
        logic [7:0] e_addr;
        logic [7:0] e_data;
        logic       e_busy;
        logic       e_terr;
        logic       e_rerr;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] rq, input logic [2:0] dn, input logic [2:0] we,
                         input logic [7:0] a0, input logic [7:0] d0,
                         input logic [7:0] a1, input logic [7:0] d1,
                         input logic [7:0] a2, input logic [7:0] d2);
        bus.req     = rq;
        bus.done    = dn;
        bus.we_in   = we;
        bus.addr_in = {a2, a1, a0};
        bus.data_in = {d2, d1, d0};
    endtask

    task automatic drive0(input logic [2:0] rq, input logic [2:0] dn, input logic [2:0] we,
                          input logic [7:0] a0, input logic [7:0] d0);
        drive(rq, dn, we, a0, d0, 8'h80, 8'h11, 8'h20, 8'h22);
    endtask

    function automatic logic [7:0] base_of(input int k);
        case (k)
            0:       return 8'hC0;
            1:       return 8'h40;
            default: return 8'h00;
        endcase
    endfunction

    // All three writers present beat b of their own record; only the owner should reach the RAM
    task automatic drive_beat(input int b, input logic last);
        drive(3'b111, last ? 3'b111 : 3'b000, 3'b111,
              base_of(0) + 8'(b), 8'(b),
              base_of(1) + 8'(b), 8'(16 + b),
              base_of(2) + 8'(b), 8'(32 + b));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive0(3'b000, 3'b000, 3'b000, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic vec_t mk(input logic [2:0] rq, input logic [2:0] dn, input logic [2:0] we,
                                input logic [7:0] a0, input logic [7:0] d0,
                                input logic [2:0] eg, input logic ewe,
                                input logic [7:0] ea, input logic [7:0] ed,
                                input logic eb, input logic et, input logic er);
        vec_t v;
        v.req = rq; v.done = dn; v.we = we; v.a0 = a0; v.d0 = d0;
        v.e_grant = eg; v.e_we = ewe; v.e_addr = ea; v.e_data = ed;
        v.e_busy = eb; v.e_terr = et; v.e_rerr = er;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int held;
        int w;
        int gap;
        int k;

        // Owner 0 burst, non-owner noise, stray done in IDLE, early release by 2, range probe
        vecs[0]  = mk(3'b001, 3'b000, 3'b000, 8'h00, 8'h00, 3'b000, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(3'b001, 3'b000, 3'b001, 8'hC0, 8'h01, 3'b001, 1'b1, 8'hC0, 8'h01, 1'b1, 1'b0, 1'b0);
        vecs[2]  = mk(3'b001, 3'b000, 3'b011, 8'hC1, 8'h03, 3'b001, 1'b1, 8'hC1, 8'h03, 1'b1, 1'b0, 1'b0);
        vecs[3]  = mk(3'b001, 3'b010, 3'b001, 8'hC2, 8'h50, 3'b001, 1'b1, 8'hC2, 8'h50, 1'b1, 1'b0, 1'b0);
        vecs[4]  = mk(3'b001, 3'b001, 3'b001, 8'hC3, 8'h30, 3'b001, 1'b1, 8'hC3, 8'h30, 1'b1, 1'b0, 1'b0);
        vecs[5]  = mk(3'b000, 3'b000, 3'b000, 8'hC4, 8'h00, 3'b000, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        vecs[6]  = mk(3'b000, 3'b001, 3'b001, 8'hC4, 8'h00, 3'b000, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        vecs[7]  = mk(3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 3'b000, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        vecs[8]  = mk(3'b100, 3'b000, 3'b000, 8'h00, 8'h00, 3'b000, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        vecs[9]  = mk(3'b100, 3'b000, 3'b100, 8'h00, 8'h00, 3'b100, 1'b1, 8'h20, 8'h22, 1'b1, 1'b0, 1'b0);
        vecs[10] = mk(3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 3'b100, 1'b0, 8'h20, 8'h22, 1'b1, 1'b0, 1'b0);
        vecs[11] = mk(3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 3'b000, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        vecs[12] = mk(3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 3'b000, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        vecs[13] = mk(3'b001, 3'b000, 3'b000, 8'h00, 8'h00, 3'b000, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        vecs[14] = mk(3'b001, 3'b000, 3'b001, 8'h10, 8'h77, 3'b001, ~RC,  8'h10, 8'h77, 1'b1, 1'b0, RC);
        vecs[15] = mk(3'b001, 3'b001, 3'b001, 8'hC4, 8'h78, 3'b001, 1'b1, 8'hC4, 8'h78, 1'b1, 1'b0, 1'b0);
        vecs[16] = mk(3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 3'b000, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        vecs[17] = mk(3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 3'b000, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        // Reset state, sampled with reset still asserted
        reset = 1'b1;
        drive0(3'b000, 3'b000, 3'b000, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        #1;
        chk("rst grant",       bus.grant,       3'b000);
        chk("rst busy",        bus.busy,        1'b0);
        chk("rst mem_we",      bus.mem_we,      1'b0);
        chk("rst mem_address", bus.mem_address, 8'h00);
        chk("rst timeout_err", bus.timeout_err, 1'b0);
        chk("rst timeout_id",  bus.timeout_id,  2'd0);
        chk("rst range_err",   bus.range_err,   1'b0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive0(vecs[i].req, vecs[i].done, vecs[i].we, vecs[i].a0, vecs[i].d0);
            #1;
            chk($sformatf("v%0d grant", i),     bus.grant,       vecs[i].e_grant);
            chk($sformatf("v%0d mem_we", i),    bus.mem_we,      vecs[i].e_we);
            chk($sformatf("v%0d mem_addr", i),  bus.mem_address, vecs[i].e_addr);
            chk($sformatf("v%0d mem_data", i),  bus.mem_data,    vecs[i].e_data);
            chk($sformatf("v%0d busy", i),      bus.busy,        vecs[i].e_busy);
            chk($sformatf("v%0d timeout_err", i), bus.timeout_err, vecs[i].e_terr);
            chk($sformatf("v%0d range_err", i), bus.range_err,   vecs[i].e_rerr);
        end

        // All three requesting continuously: strict rotation 0,1,2,0 with a 2-cycle gap
        do_reset();
        @(negedge clk);
        drive(3'b111, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        #1;
        chk("rr idle grant", bus.grant, 3'b000);
        for (int n = 0; n < 4; n++) begin
            k   = n % 3;
            gap = 0;
            w   = 0;
            while (w < 10) begin
                @(negedge clk);
                drive_beat(0, 1'b0);
                #1;
                if (bus.grant != 3'b000) break;
                gap++;
                chk($sformatf("rr%0d gap mem_we", n), bus.mem_we, 1'b0);
                w++;
            end
            chk($sformatf("rr%0d grant", n), bus.grant, 3'b001 << k);
            if (n > 0) chk($sformatf("rr%0d gap cycles", n), gap, 2);
            for (int b = 0; b < 4; b++) begin
                if (b > 0) begin
                    @(negedge clk);
                    drive_beat(b, b == 3);
                    #1;
                end
                chk($sformatf("rr%0d b%0d grant", n, b), bus.grant, 3'b001 << k);
                chk($sformatf("rr%0d b%0d mem_we", n, b), bus.mem_we, 1'b1);
                chk($sformatf("rr%0d b%0d addr", n, b), bus.mem_address, base_of(k) + 8'(b));
                chk($sformatf("rr%0d b%0d data", n, b), bus.mem_data, 8'(16 * k + b));
            end
        end
        @(negedge clk);
        drive0(3'b000, 3'b000, 3'b000, 8'h00, 8'h00);
        repeat (2) @(negedge clk);

        // Watchdog: owner 1 never finishes, requester 2 waits behind it
        do_reset();
        @(negedge clk);
        drive0(3'b110, 3'b000, 3'b000, 8'h00, 8'h00);
        #1;
        w = 0;
        while (bus.grant == 3'b000 && w < 10) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk("to first grant", bus.grant, 3'b010);
        held = 0;
        while (bus.grant == 3'b010 && held < 300) begin
            held++;
            @(negedge clk);
            #1;
        end
        chk("to hold cycles", held, 64);
        chk("to gap grant",  bus.grant,       3'b000);
        chk("to err pulse",  bus.timeout_err, 1'b1);
        chk("to err id",     bus.timeout_id,  2'd1);
        chk("to gap busy",   bus.busy,        1'b1);
        @(negedge clk);
        #1;
        chk("to err one-shot", bus.timeout_err, 1'b0);
        chk("to idle grant",   bus.grant,       3'b000);
        @(negedge clk);
        #1;
        chk("to next grant",   bus.grant,       3'b100);
        @(negedge clk);
        drive0(3'b000, 3'b000, 3'b000, 8'h00, 8'h00);
        #1;
        @(negedge clk);
        #1;
        chk("to release no err", bus.timeout_err, 1'b0);
        @(negedge clk);
        #1;
        chk("to release idle busy", bus.busy,       1'b0);
        chk("to id held",           bus.timeout_id, 2'd1);

        // Reset in the middle of owner 0's burst, with requester 1 also pending
        @(negedge clk);
        drive0(3'b011, 3'b000, 3'b011, 8'hC0, 8'hAA);
        #1;
        @(negedge clk);
        #1;
        chk("mr grant",  bus.grant,       3'b001);
        chk("mr w0 we",  bus.mem_we,      1'b1);
        chk("mr w0 adr", bus.mem_address, 8'hC0);
        @(negedge clk);
        drive0(3'b011, 3'b000, 3'b011, 8'hC1, 8'hAB);
        #1;
        chk("mr w1 adr", bus.mem_address, 8'hC1);
        @(negedge clk);
        reset = 1'b1;
        drive0(3'b011, 3'b000, 3'b011, 8'hC2, 8'hAC);
        @(negedge clk);
        reset = 1'b0;
        drive0(3'b011, 3'b000, 3'b011, 8'hC3, 8'hAD);
        #1;
        chk("mr post grant",  bus.grant,       3'b000);
        chk("mr post mem_we", bus.mem_we,      1'b0);
        chk("mr post busy",   bus.busy,        1'b0);
        chk("mr post err",    bus.timeout_err, 1'b0);
        @(negedge clk);
        #1;
        chk("mr regrant 0", bus.grant, 3'b001);
        @(negedge clk);
        drive0(3'b000, 3'b000, 3'b000, 8'h00, 8'h00);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
